// File: rtl/risc_pkg.sv
// Definitions shared by the RISC memory subsystem: memory geometry,
// arbiter priority states and the load/store opcodes used in memory images.
package risc_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 8;
    localparam int unsigned MEM_DATA_WIDTH = 16;

    typedef enum logic {
        PRI_DATA  = 1'b0,
        PRI_FETCH = 1'b1
    } arb_state_e;

    localparam logic [3:0] OPC_LW = 4'h9;
    localparam logic [3:0] OPC_SW = 4'hA;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between instruction fetch and load/store.
// Data normally wins; a starvation counter hands priority to fetch.
module mem_port_arbiter
    import risc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_rvalid,
    input  logic                  ds_req,
    input  logic                  ds_we,
    input  logic [ADDR_WIDTH-1:0] ds_addr,
    input  logic [DATA_WIDTH-1:0] ds_wdata,
    output logic                  ds_gnt,
    output logic [DATA_WIDTH-1:0] ds_rdata,
    output logic                  ds_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned      CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] ds_rdata_q, ds_rdata_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic                  ds_rvalid_q, ds_rvalid_d;
    logic                  if_gnt_c, ds_gnt_c, ds_rd_c;

    always_comb begin
        if_gnt_c   = 1'b0;
        ds_gnt_c   = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        if (!rst) begin
            case (state_q)
                PRI_DATA: begin
                    ds_gnt_c = ds_req;
                    if_gnt_c = if_req & ~ds_req;
                end
                PRI_FETCH: begin
                    if_gnt_c = if_req;
                    ds_gnt_c = ds_req & ~if_req;
                end
                default: ;
            endcase
        end

        if (!if_req || if_gnt_c) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end

        // Switch on the edge where the count reaches the limit, so fetch wins
        // the cycle right after its MAX_WAIT-th consecutive denial.
        case (state_q)
            PRI_DATA:  if (wait_cnt_d == WAIT_LIMIT) state_d = PRI_FETCH;
            PRI_FETCH: if (if_gnt_c || !if_req)      state_d = PRI_DATA;
            default:   state_d = PRI_DATA;
        endcase
    end

    always_comb begin
        ds_rd_c     = ds_gnt_c & ~ds_we;
        if_rvalid_d = if_gnt_c;
        ds_rvalid_d = ds_rd_c;
        if_rdata_d  = if_gnt_c ? mem_rdata : if_rdata_q;
        ds_rdata_d  = ds_rd_c  ? mem_rdata : ds_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PRI_DATA;
            wait_cnt_q  <= '0;
            if_rdata_q  <= '0;
            ds_rdata_q  <= '0;
            if_rvalid_q <= 1'b0;
            ds_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            if_rdata_q  <= if_rdata_d;
            ds_rdata_q  <= ds_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            ds_rvalid_q <= ds_rvalid_d;
        end
    end

    assign if_gnt    = if_gnt_c;
    assign ds_gnt    = ds_gnt_c;
    assign mem_addr  = ds_gnt_c ? ds_addr : if_addr;
    assign mem_wr    = ds_gnt_c & ds_we & ~rst;
    assign mem_wdata = ds_wdata;
    assign if_rdata  = if_rdata_q;
    assign ds_rdata  = ds_rdata_q;
    // A read answer due in a cycle where reset is asserted is dropped.
    assign if_rvalid = if_rvalid_q & ~rst;
    assign ds_rvalid = ds_rvalid_q & ~rst;

endmodule
